// File: rtl/dac_write_sequencer_if.sv
// Host write port and SPI controller handshake for dac_write_sequencer.
// The sequencer side uses the slave modport; the host/SPI side uses master.
interface dac_write_sequencer_if #(
    parameter int CH_BITS    = 2,
    parameter int DATA_WIDTH = 16
);
    logic                  wr_valid_in;
    logic [CH_BITS-1:0]    wr_ch_in;
    logic [DATA_WIDTH-1:0] wr_data_in;
    logic                  wr_ready_out;
    logic                  spi_trigger_out;
    logic [DATA_WIDTH+7:0] spi_data_out;
    logic                  spi_ready_in;

    modport master (
        output wr_valid_in, wr_ch_in, wr_data_in, spi_ready_in,
        input  wr_ready_out, spi_trigger_out, spi_data_out
    );

    modport slave (
        input  wr_valid_in, wr_ch_in, wr_data_in, spi_ready_in,
        output wr_ready_out, spi_trigger_out, spi_data_out
    );
endinterface

// File: rtl/dac_write_sequencer.sv
// Shadow-register write sequencer feeding an SPI controller, lowest pending channel first.
// Define DAC_SEQ_LDAC_EN for write-only commands plus an ldac_n_out pulse after the queue drains.
module dac_write_sequencer #(
    parameter int         N_CH           = 4,
    parameter int         CH_BITS        = 2,
    parameter int         DATA_WIDTH     = 16,
    parameter logic [3:0] CMD_WRITE      = 4'h1,
    parameter logic [3:0] CMD_WRITE_UPD  = 4'h3,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter int         LDAC_CYCLES    = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    dac_write_sequencer_if.slave  bus,
    output logic [N_CH-1:0]       pending_out,
    output logic                  busy_out,
    output logic                  err_range_out,
    output logic                  err_timeout_out,
    input  logic                  err_clr_in
`ifdef DAC_SEQ_LDAC_EN
    ,
    output logic                  ldac_n_out
`endif
);

`ifdef DAC_SEQ_LDAC_EN
    localparam bit LDAC_EN = 1'b1;
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_BUSY, WAIT_DONE, LDAC} state_t;
`else
    localparam bit LDAC_EN = 1'b0;
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_BUSY, WAIT_DONE} state_t;
`endif

    localparam logic [3:0]  CMD     = LDAC_EN ? CMD_WRITE : CMD_WRITE_UPD;
    localparam logic [12:0] TO_LAST = 13'(TIMEOUT_CYCLES - 1);

    if (N_CH < 1 || N_CH > 16 || N_CH > (1 << CH_BITS) ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 8192 || LDAC_CYCLES < 1) begin : g_param_check
        $error("dac_write_sequencer: illegal parameter combination");
    end

    state_t                state, state_nxt;
    logic                  wr_ready;
    logic [N_CH-1:0]       pending;
    logic [DATA_WIDTH-1:0] shadow [N_CH];
    logic [3:0]            sel;
    logic [DATA_WIDTH+7:0] spi_data;
    logic [12:0]           cnt;
    logic                  err_range, err_timeout;

    logic                  wr_acc, wr_bad;
    logic [N_CH-1:0]       wr_hit;
    logic [3:0]            first;
    logic [DATA_WIDTH-1:0] sh_first;
    logic                  load, clr_sel, retry, cnt_clr, timeout_hit;

    function automatic logic [3:0] lowest_set(input logic [N_CH-1:0] p);
        logic [3:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (p[i]) r = 4'(i);
        end
        return r;
    endfunction

    assign wr_acc      = bus.wr_valid_in && wr_ready;
    assign wr_bad      = wr_acc && (int'(bus.wr_ch_in) >= N_CH);
    assign first       = lowest_set(pending);
    assign timeout_hit = (cnt == TO_LAST);

    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_hit[i] = wr_acc && (int'(bus.wr_ch_in) == i);
        end
    end

    always_comb begin
        sh_first = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(first) == i) sh_first = shadow[i];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        clr_sel   = 1'b0;
        retry     = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            IDLE: begin
                // SPI not ready also covers the controller's power-up window
                if ((pending != '0) && bus.spi_ready_in) begin
                    load      = 1'b1;
                    state_nxt = TRIG;
                end
            end
            TRIG: begin
                clr_sel   = 1'b1;
                cnt_clr   = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!bus.spi_ready_in) begin
                    cnt_clr   = 1'b1;
                    state_nxt = WAIT_DONE;
                end else if (timeout_hit) begin
                    retry     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (bus.spi_ready_in) begin
                    cnt_clr = 1'b1;
`ifdef DAC_SEQ_LDAC_EN
                    state_nxt = (pending == '0) ? LDAC : IDLE;
`else
                    state_nxt = IDLE;
`endif
                end else if (timeout_hit) begin
                    retry     = 1'b1;
                    state_nxt = IDLE;
                end
            end
`ifdef DAC_SEQ_LDAC_EN
            LDAC: begin
                if (cnt == 13'(LDAC_CYCLES - 1)) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Pending-bit priority: a host write beats both the TRIG clear and the timeout retry
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ready    <= 1'b0;
            pending     <= '0;
            sel         <= '0;
            spi_data    <= '0;
            cnt         <= '0;
            err_range   <= 1'b0;
            err_timeout <= 1'b0;
            for (int i = 0; i < N_CH; i++) shadow[i] <= '0;
        end else begin
            wr_ready <= 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                if (wr_hit[i]) begin
                    shadow[i]  <= bus.wr_data_in;
                    pending[i] <= 1'b1;
                end else if (retry && (int'(sel) == i)) begin
                    pending[i] <= 1'b1;
                end else if (clr_sel && (int'(sel) == i)) begin
                    pending[i] <= 1'b0;
                end
            end
            if (load) begin
                sel      <= first;
                spi_data <= {CMD, first, sh_first};
            end
            cnt <= cnt_clr ? 13'd0 : cnt + 13'd1;
            if (wr_bad)          err_range <= 1'b1;
            else if (err_clr_in) err_range <= 1'b0;
            if (retry)           err_timeout <= 1'b1;
            else if (err_clr_in) err_timeout <= 1'b0;
        end
    end

    assign bus.wr_ready_out    = wr_ready;
    assign bus.spi_trigger_out = (state == TRIG);
    assign bus.spi_data_out    = spi_data;
    assign pending_out         = pending;
    assign busy_out            = (pending != '0) || (state != IDLE);
    assign err_range_out       = err_range;
    assign err_timeout_out     = err_timeout;
`ifdef DAC_SEQ_LDAC_EN
    assign ldac_n_out          = (state != LDAC);
`endif

endmodule

// File: tb/tb_dac_write_sequencer.sv
// Directed bench for dac_write_sequencer with a behavioural SPI controller model.
// Honours DAC_SEQ_LDAC_EN the same way as the design.
module tb_dac_write_sequencer;
    localparam int N_CH = 4;
    localparam int CH_BITS = 3;
    localparam int DW = 16;
`ifdef DAC_SEQ_LDAC_EN
    localparam logic [3:0] CMD = 4'h1;
`else
    localparam logic [3:0] CMD = 4'h3;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic err_clr;
    logic [N_CH-1:0] pending;
    logic busy, err_range, err_timeout;
`ifdef DAC_SEQ_LDAC_EN
    logic ldac_n;
    int   ldac_lows = 0;
`endif

    int n_vec = 0;
    int n_miss = 0;

    logic spi_rdy;
    logic stuck = 1'b0;
    int   spi_cnt;
    logic [DW+7:0] trig_q[$];

    dac_write_sequencer_if #(.CH_BITS(CH_BITS), .DATA_WIDTH(DW)) bus ();

    dac_write_sequencer #(
        .N_CH(N_CH), .CH_BITS(CH_BITS), .DATA_WIDTH(DW),
        .CMD_WRITE(4'h1), .CMD_WRITE_UPD(4'h3),
        .TIMEOUT_CYCLES(4096), .LDAC_CYCLES(4)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .bus(bus),
        .pending_out(pending),
        .busy_out(busy),
        .err_range_out(err_range),
        .err_timeout_out(err_timeout),
        .err_clr_in(err_clr)
`ifdef DAC_SEQ_LDAC_EN
        ,
        .ldac_n_out(ldac_n)
`endif
    );

    always #5 clk = ~clk;

    assign bus.spi_ready_in = spi_rdy;

    // SPI controller model: ready drops the cycle after a trigger, returns 200 cycles later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_rdy <= 1'b1;
            spi_cnt <= 0;
        end else if (!stuck && bus.spi_trigger_out) begin
            spi_rdy <= 1'b0;
            spi_cnt <= 200;
        end else if (spi_cnt != 0) begin
            spi_cnt <= spi_cnt - 1;
            if (spi_cnt == 1) spi_rdy <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (bus.spi_trigger_out === 1'b1) trig_q.push_back(bus.spi_data_out);
`ifdef DAC_SEQ_LDAC_EN
        if (ldac_n === 1'b0) ldac_lows++;
`endif
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] w(input int ch, input logic [15:0] d);
        return {8'd0, CMD, 4'(ch), d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int ch, input logic [15:0] d);
        bus.wr_valid_in = 1'b1;
        bus.wr_ch_in    = 3'(ch);
        bus.wr_data_in  = d;
        @(negedge clk);
        bus.wr_valid_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int k = 0;
        while (busy && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        int k;
`ifdef DAC_SEQ_LDAC_EN
        int lbase;
`endif
        rst_n = 1'b0;
        err_clr = 1'b0;
        bus.wr_valid_in = 1'b0;
        bus.wr_ch_in = '0;
        bus.wr_data_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_wr_ready", 32'(bus.wr_ready_out), 32'd0);
        chk("rst_trigger", 32'(bus.spi_trigger_out), 32'd0);
        chk("rst_spi_data", 32'(bus.spi_data_out), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_errs", {30'd0, err_range, err_timeout}, 32'd0);
`ifdef DAC_SEQ_LDAC_EN
        chk("rst_ldac_n", 32'(ldac_n), 32'd1);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("wr_ready_after_rst", 32'(bus.wr_ready_out), 32'd1);

        // single write, latency and word format
        base = trig_q.size();
`ifdef DAC_SEQ_LDAC_EN
        lbase = ldac_lows;
`endif
        wr(2, 16'hABCD);
        chk("single_pend_set", 32'(pending), 32'h4);
        @(negedge clk);
        chk("single_trigger", 32'(bus.spi_trigger_out), 32'd1);
        chk("single_data", 32'(bus.spi_data_out), w(2, 16'hABCD));
        @(negedge clk);
        chk("single_pend_clr", 32'(pending), 32'd0);
        chk("single_trig_1cyc", 32'(bus.spi_trigger_out), 32'd0);
        chk("single_busy", 32'(busy), 32'd1);
        wait_idle("single_idle", 1000);
        chk("single_ntrig", 32'(trig_q.size() - base), 32'd1);
`ifdef DAC_SEQ_LDAC_EN
        chk("single_ldac_len", 32'(ldac_lows - lbase), 32'd4);
`endif

        // burst queued behind an active transfer drains lowest-first
        base = trig_q.size();
`ifdef DAC_SEQ_LDAC_EN
        lbase = ldac_lows;
`endif
        wr(2, 16'h0009);
        wr(3, 16'h0001);
        wr(0, 16'h0002);
        wr(1, 16'h0003);
        chk("burst_data_held", 32'(bus.spi_data_out), w(2, 16'h0009));
        chk("burst_pending", 32'(pending), 32'hB);
        wait_idle("burst_idle", 2000);
        chk("burst_ntrig", 32'(trig_q.size() - base), 32'd4);
        chk("burst_t0", 32'(trig_q[base]),   w(2, 16'h0009));
        chk("burst_t1", 32'(trig_q[base+1]), w(0, 16'h0002));
        chk("burst_t2", 32'(trig_q[base+2]), w(1, 16'h0003));
        chk("burst_t3", 32'(trig_q[base+3]), w(3, 16'h0001));
`ifdef DAC_SEQ_LDAC_EN
        chk("burst_ldac_len", 32'(ldac_lows - lbase), 32'd4);
`endif

        // repeated writes to a still-pending channel coalesce
        base = trig_q.size();
        wr(2, 16'h0011);
        wr(1, 16'h0005);
        wr(1, 16'h0007);
        wait_idle("coal_idle", 1000);
        chk("coal_ntrig", 32'(trig_q.size() - base), 32'd2);
        chk("coal_t0", 32'(trig_q[base]),   w(2, 16'h0011));
        chk("coal_t1", 32'(trig_q[base+1]), w(1, 16'h0007));

        // write landing in the channel's own TRIG cycle is resent
        base = trig_q.size();
        wr(0, 16'h0100);
        @(negedge clk);
        chk("own_trig_trigger", 32'(bus.spi_trigger_out), 32'd1);
        bus.wr_valid_in = 1'b1;
        bus.wr_ch_in    = 3'd0;
        bus.wr_data_in  = 16'h0200;
        @(negedge clk);
        bus.wr_valid_in = 1'b0;
        chk("own_trig_pend", 32'(pending), 32'h1);
        chk("own_trig_data_held", 32'(bus.spi_data_out), w(0, 16'h0100));
        wait_idle("own_trig_idle", 1000);
        chk("own_trig_ntrig", 32'(trig_q.size() - base), 32'd2);
        chk("own_trig_t0", 32'(trig_q[base]),   w(0, 16'h0100));
        chk("own_trig_t1", 32'(trig_q[base+1]), w(0, 16'h0200));

        // out-of-range channel
        base = trig_q.size();
        wr(5, 16'h0055);
        chk("range_err", 32'(err_range), 32'd1);
        chk("range_pend", 32'(pending), 32'd0);
        chk("range_busy", 32'(busy), 32'd0);
        bus.wr_valid_in = 1'b1;
        bus.wr_ch_in    = 3'd6;
        err_clr = 1'b1;
        @(negedge clk);
        bus.wr_valid_in = 1'b0;
        chk("range_set_wins", 32'(err_range), 32'd1);
        @(negedge clk);
        err_clr = 1'b0;
        chk("range_clr", 32'(err_range), 32'd0);
        repeat (4) @(negedge clk);
        chk("range_ntrig", 32'(trig_q.size() - base), 32'd0);

        // SPI never drops ready -> timeout, retry once it behaves again
        stuck = 1'b1;
        base = trig_q.size();
        wr(3, 16'h0033);
        k = 0;
        while (bus.spi_trigger_out !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("to_trigger", 32'(bus.spi_trigger_out), 32'd1);
        k = 0;
        while (err_timeout !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("to_cycles", 32'(k), 32'd4097);
        chk("to_err", 32'(err_timeout), 32'd1);
        chk("to_pend_retry", 32'(pending), 32'h8);
        stuck = 1'b0;
        wait_idle("to_idle", 1000);
        chk("to_ntrig", 32'(trig_q.size() - base), 32'd2);
        chk("to_t0", 32'(trig_q[base]),   w(3, 16'h0033));
        chk("to_t1", 32'(trig_q[base+1]), w(3, 16'h0033));
        chk("to_err_sticky", 32'(err_timeout), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("to_clr", 32'(err_timeout), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
